// File: rtl/icache_o128_if.sv
// SRAM line-read bus: the instruction cache is the master, the 128-bit SRAM the slave.
// The read request and the line address stay stable until the SRAM pulses mem_valid.
interface icache_o128_if #(
  parameter int ADDR_SIZE = 10
);
  logic                 mem_re;
  logic [3:0]           mem_ble;
  logic [ADDR_SIZE-1:0] mem_add;
  logic                 mem_valid;
  logic [3:0][31:0]     mem_d;

  modport master (output mem_re, mem_ble, mem_add, input mem_valid, mem_d);
  modport slave  (input mem_re, mem_ble, mem_add, output mem_valid, mem_d);
endinterface

// File: rtl/icache_o128.sv
// icache_o128: direct-mapped instruction cache with 4-word lines, zero-latency hits
// and a single-beat line refill; fetch stalls while a refill is outstanding.
module icache_o128 #(
  parameter int NB_LINES  = 16,
  parameter int ADDR_SIZE = 10
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          cpu_req_i,
  input  logic [31:0]   cpu_addr_i,
  output logic [31:0]   cpu_instr_o,
  output logic          cpu_valid_o,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o,
  icache_o128_if.master mem
);
  localparam int IDX = $clog2(NB_LINES);
  localparam int TAG = ADDR_SIZE - 2 - IDX;

  typedef enum logic [0:0] {IDLE = 1'b0, REFILL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [3:0][31:0]    data_q [NB_LINES];
  logic [TAG-1:0]      tag_q  [NB_LINES];
  logic [NB_LINES-1:0] valid_q;
  logic [TAG-1:0]      rtag_q;
  logic [IDX-1:0]      ridx_q;
  logic [31:0]         hit_cnt_q, miss_cnt_q;

  logic [1:0]          off_s;
  logic [IDX-1:0]      idx_s;
  logic [TAG-1:0]      tag_s;
  logic                hit_s, miss_start_s, refill_done_s;
  logic                unused_s;

  assign off_s = cpu_addr_i[3:2];
  assign idx_s = cpu_addr_i[3+IDX:4];
  assign tag_s = cpu_addr_i[ADDR_SIZE+1:4+IDX];
  assign unused_s = ^{cpu_addr_i[31:ADDR_SIZE+2], cpu_addr_i[1:0]};

  // Lookups only count in IDLE: a refill blocks every hit, even to other lines.
  assign hit_s = cpu_req_i && valid_q[idx_s] && (tag_q[idx_s] == tag_s) && (state_q == IDLE);
  assign miss_start_s  = (state_q == IDLE) && cpu_req_i && !hit_s && !flush_i;
  assign refill_done_s = (state_q == REFILL) && mem.mem_valid;

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (miss_start_s) begin
          state_d = REFILL;
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (mem.mem_valid) begin
          state_d = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: fetch response and SRAM request
  always_comb begin
    cpu_valid_o = 1'b0;
    cpu_instr_o = 32'h0000_0000;
    mem.mem_re  = 1'b0;
    mem.mem_add = '0;
    mem.mem_ble = 4'b1111;
    if (hit_s) begin
      cpu_valid_o = 1'b1;
      cpu_instr_o = data_q[idx_s][off_s];
    end else begin
      cpu_valid_o = 1'b0;
      cpu_instr_o = 32'h0000_0000;
    end
    if (state_q == REFILL) begin
      mem.mem_re  = 1'b1;
      mem.mem_add = {rtag_q, ridx_q, 2'b00};
    end else begin
      mem.mem_re  = 1'b0;
      mem.mem_add = '0;
    end
  end

  // Refill target latch, valid bits and event counters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rtag_q     <= '0;
      ridx_q     <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (miss_start_s) begin
        rtag_q     <= tag_s;
        ridx_q     <= idx_s;
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (hit_s) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      // A flush on the refill-complete edge wins: the line is written but stays invalid.
      if (flush_i) begin
        valid_q <= '0;
      end else if (refill_done_s) begin
        valid_q[ridx_q] <= 1'b1;
      end
    end
  end

  // Line storage is never reset; the valid bits guard it.
  always_ff @(posedge clk_i) begin
    if (refill_done_s) begin
      data_q[ridx_q] <= mem.mem_d;
      tag_q[ridx_q]  <= rtag_q;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
endmodule

// File: tb/tb_icache_o128.sv
// Self-checking bench for icache_o128 with a wait-state SRAM model and an instruction scoreboard.
module tb_icache_o128;
  logic        clk = 1'b0;
  logic        rstn, flush, req;
  logic [31:0] addr;
  logic [31:0] instr, hits, misses;
  logic        vld;
  int          ws = 2;
  int          wcnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  icache_o128_if #(.ADDR_SIZE(10)) bus();

  icache_o128 #(.NB_LINES(16), .ADDR_SIZE(10)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .cpu_req_i(req), .cpu_addr_i(addr),
    .cpu_instr_o(instr), .cpu_valid_o(vld), .hit_cnt_o(hits), .miss_cnt_o(misses),
    .mem(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input int a);
    return {16'hA5C3, 6'h00, a[9:0]};
  endfunction

  assign bus.mem_valid = bus.mem_re && (wcnt == ws);
  assign bus.mem_d = {mw(int'(bus.mem_add) + 3), mw(int'(bus.mem_add) + 2),
                      mw(int'(bus.mem_add) + 1), mw(int'(bus.mem_add))};

  always @(posedge clk) begin
    if (!bus.mem_re || bus.mem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic do_fetch(input logic [31:0] a, output int lat, output int re_cyc,
                          output logic [9:0] add_seen, output logic [31:0] ins, output bit got);
    lat = 0; re_cyc = 0; add_seen = 10'h000; ins = 32'h0; got = 1'b0;
    @(negedge clk); req = 1'b1; addr = a;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (vld) begin
        got = 1'b1; ins = instr; lat = c;
        break;
      end
      if (bus.mem_re) begin
        re_cyc++;
        add_seen = bus.mem_add;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk); req = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; req = 1'b0; addr = 32'h0;
    #1;
    n_checks++;
    if (vld !== 1'b0 || instr !== 32'h0 || bus.mem_re !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: vld=%b instr=%h re=%b expected 0/0/0", vld, instr, bus.mem_re);
    end
    n_checks++;
    if (hits !== 32'd0 || misses !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: hits=%0d misses=%0d expected 0/0", hits, misses);
    end
    n_checks++;
    if (bus.mem_ble !== 4'b1111 || bus.mem_add !== 10'h000) begin
      n_fail++; $display("FAIL reset_bus: ble=%b add=%h expected 1111/000", bus.mem_ble, bus.mem_add);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_miss();
    int lat, rc; logic [9:0] ad; logic [31:0] ins; bit got;
    ws = 2;
    exp_q.push_back(mw(32'h10 >> 2));
    do_fetch(32'h10, lat, rc, ad, ins, got);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || ins !== exp_w) begin n_fail++; $display("FAIL miss_data: got %h expected %h", ins, exp_w); end
    n_checks++;
    if (lat !== 4 || rc !== 3) begin n_fail++; $display("FAIL miss_timing: lat=%0d re=%0d expected 4/3", lat, rc); end
    n_checks++;
    if (ad !== 10'h004) begin n_fail++; $display("FAIL miss_addr: got %h expected 004", ad); end
    idle_cycle();
    n_checks++;
    if (hits !== 32'd1 || misses !== 32'd1) begin
      n_fail++; $display("FAIL miss_counters: hits=%0d misses=%0d expected 1/1", hits, misses);
    end
  endtask

  task automatic test_sweep();
    int lat, rc; logic [9:0] ad; logic [31:0] ins; bit got;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mw(4 + i));
      do_fetch(32'h10 + 32'(4 * i), lat, rc, ad, ins, got);
      exp_w = exp_q.pop_front();
      n_checks++;
      if (!got || ins !== exp_w || lat !== 0 || rc !== 0) begin
        n_fail++; $display("FAIL sweep_hit%0d: got %h lat=%0d re=%0d expected %h lat=0 re=0", i, ins, lat, rc, exp_w);
      end
    end
    idle_cycle();
    n_checks++;
    if (hits !== 32'd5 || misses !== 32'd1) begin
      n_fail++; $display("FAIL sweep_counters: hits=%0d misses=%0d expected 5/1", hits, misses);
    end
  endtask

  task automatic test_conflict();
    int lat, rc; logic [9:0] ad; logic [31:0] ins; bit got;
    exp_q.push_back(mw(32'h110 >> 2));
    do_fetch(32'h110, lat, rc, ad, ins, got);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || ins !== exp_w || ad !== 10'h044 || lat !== 4) begin
      n_fail++; $display("FAIL conflict_fill: got %h add=%h lat=%0d expected %h add=044 lat=4", ins, ad, lat, exp_w);
    end
    exp_q.push_back(mw(32'h10 >> 2));
    do_fetch(32'h10, lat, rc, ad, ins, got);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || ins !== exp_w || lat !== 4 || ad !== 10'h004) begin
      n_fail++; $display("FAIL conflict_refetch: got %h lat=%0d add=%h expected %h lat=4 add=004", ins, lat, ad, exp_w);
    end
    idle_cycle();
    n_checks++;
    if (misses !== 32'd3) begin n_fail++; $display("FAIL conflict_misses: got %0d expected 3", misses); end
  endtask

  task automatic test_ws0();
    int lat, rc; logic [9:0] ad; logic [31:0] ins; bit got;
    ws = 0;
    exp_q.push_back(mw(32'h200 >> 2));
    do_fetch(32'h200, lat, rc, ad, ins, got);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || ins !== exp_w || lat !== 2 || rc !== 1 || ad !== 10'h080) begin
      n_fail++; $display("FAIL ws0_miss: got %h lat=%0d re=%0d add=%h expected %h 2 1 080", ins, lat, rc, ad, exp_w);
    end
    idle_cycle();
    ws = 2;
  endtask

  task automatic test_addr_change();
    int lat, rc; logic [9:0] ad; logic [31:0] ins; bit got;
    @(negedge clk); req = 1'b1; addr = 32'h300;
    for (int c = 0; c <= ws; c++) begin
      @(negedge clk);
      if (c == 0) begin addr = 32'h10; exp_q.push_back(mw(4)); end
      #1;
      n_checks++;
      if (bus.mem_re !== 1'b1 || vld !== 1'b0) begin
        n_fail++; $display("FAIL refill_no_hit c%0d: re=%b vld=%b expected 1/0", c, bus.mem_re, vld);
      end
    end
    @(negedge clk); #1;
    exp_w = exp_q.pop_front();
    n_checks++;
    if (vld !== 1'b1 || instr !== exp_w) begin
      n_fail++; $display("FAIL after_refill_hit: vld=%b instr=%h expected 1 %h", vld, instr, exp_w);
    end
    exp_q.push_back(mw(32'h300 >> 2));
    do_fetch(32'h300, lat, rc, ad, ins, got);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || ins !== exp_w || lat !== 0 || misses !== 32'd5) begin
      n_fail++; $display("FAIL latched_line: got %h lat=%0d misses=%0d expected %h 0 5", ins, lat, misses, exp_w);
    end
    idle_cycle();
  endtask

  task automatic test_flush_idle();
    int lat, rc; logic [9:0] ad; logic [31:0] ins; bit got;
    @(negedge clk); req = 1'b1; addr = 32'h300; flush = 1'b1;
    exp_q.push_back(mw(32'h300 >> 2));
    #1;
    exp_w = exp_q.pop_front();
    n_checks++;
    if (vld !== 1'b1 || instr !== exp_w) begin
      n_fail++; $display("FAIL flush_same_cycle_hit: vld=%b instr=%h expected 1 %h", vld, instr, exp_w);
    end
    idle_cycle();
    n_checks++;
    if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL flush_no_refill: re=%b expected 0", bus.mem_re); end
    exp_q.push_back(mw(32'h300 >> 2));
    do_fetch(32'h300, lat, rc, ad, ins, got);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || ins !== exp_w || lat !== 4 || misses !== 32'd6) begin
      n_fail++; $display("FAIL flush_then_miss: got %h lat=%0d misses=%0d expected %h 4 6", ins, lat, misses, exp_w);
    end
    idle_cycle();
  endtask

  task automatic test_flush_valid();
    bit found = 1'b0;
    bit got = 1'b0;
    logic [31:0] m0 = misses;
    @(negedge clk); req = 1'b1; addr = 32'h20;
    exp_q.push_back(mw(32'h20 >> 2));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_valid) begin found = 1'b1; flush = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL flush_valid_wait: mem_valid=0 expected 1 within 20 cycles"); end
    @(negedge clk); flush = 1'b0; #1;
    n_checks++;
    if (bus.mem_re !== 1'b0 || vld !== 1'b0) begin
      n_fail++; $display("FAIL flush_wins_idle: re=%b vld=%b expected 0/0", bus.mem_re, vld);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.mem_re !== 1'b1 || misses !== m0 + 32'd2) begin
      n_fail++; $display("FAIL flush_wins_remiss: re=%b misses=%0d expected 1 %0d", bus.mem_re, misses, m0 + 32'd2);
    end
    for (int c = 0; c < 20; c++) begin
      if (vld) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || instr !== exp_w) begin
      n_fail++; $display("FAIL flush_wins_refill: got %h vld=%b expected %h", instr, vld, exp_w);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int lat, rc; logic [9:0] ad; logic [31:0] ins; bit got;
    ws = 3;
    @(negedge clk); req = 1'b1; addr = 32'h400;
    @(negedge clk); #1;
    n_checks++;
    if (bus.mem_re !== 1'b1) begin n_fail++; $display("FAIL reset_mid_refill: re=%b expected 1", bus.mem_re); end
    @(negedge clk); #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_re !== 1'b0 || vld !== 1'b0 || hits !== 32'd0 || misses !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_async: re=%b vld=%b hits=%0d misses=%0d expected 0 0 0 0", bus.mem_re, vld, hits, misses);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1; req = 1'b0;
    exp_q.push_back(mw(32'h20 >> 2));
    do_fetch(32'h20, lat, rc, ad, ins, got);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!got || ins !== exp_w || lat !== 5 || rc !== 4) begin
      n_fail++; $display("FAIL reset_then_miss: got %h lat=%0d re=%0d expected %h 5 4", ins, lat, rc, exp_w);
    end
    idle_cycle();
    n_checks++;
    if (misses !== 32'd1 || hits !== 32'd1) begin
      n_fail++; $display("FAIL reset_then_counters: misses=%0d hits=%0d expected 1/1", misses, hits);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_sweep();
    test_conflict();
    test_ws0();
    test_addr_change();
    test_flush_idle();
    test_flush_valid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_o128.md
Name: icache_o128

Overview:
- Direct-mapped instruction cache with 4-word (128-bit) lines, sitting between the core's fetch stage and the 128-bit-output instruction SRAM.
- Acts as the initiator of the SRAM handshake: it holds a read request and an aligned line address until the memory's valid pulse, then captures the whole line in one cycle.
- Hits are served combinationally. Misses stall fetch for the duration of a refill.

Parameters:
- NB_LINES, 16: number of cache lines; power of 2, at least 2.
- ADDR_SIZE, 10: width of the SRAM word address (1024 words for a 4 KiB SRAM).
- Derived widths:
  - OFF = 2 bits, word offset, cpu_addr_i[3:2].
  - IDX = log2(NB_LINES), from cpu_addr_i[3+IDX:4].
  - TAG = ADDR_SIZE-2-IDX, from cpu_addr_i[ADDR_SIZE+1:4+IDX].

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  invalidate all lines (e.g. fence.i)
- cpu_req_i  in  1  fetch request
- cpu_addr_i  in  32  fetch byte address; bits [1:0] ignored, bits above ADDR_SIZE+1 ignored
- cpu_instr_o  out  32  fetched instruction word
- cpu_valid_o  out  1  cpu_instr_o valid this cycle
- mem_re_o  out  1  SRAM read request
- mem_ble_o  out  4  byte lane enables, constant 4'b1111
- mem_add_o  out  ADDR_SIZE  line-aligned SRAM word address, {tag,index,2'b00}
- mem_valid_i  in  1  SRAM transfer complete (combinational, coincides with the last wait state)
- mem_d_i  in  4x32  line data; word k is at mem_d_i[k]
- hit_cnt_o  out  32  number of hits served
- miss_cnt_o  out  32  number of refills started

Behaviour:
- Storage:
  - Data array NB_LINES x 128 bits, tag array NB_LINES x TAG bits, valid bit vector NB_LINES bits.
  - Only the valid bits and the control state are reset.
- Reset (rstn_i=0, asynchronous):
  - FSM goes to IDLE and all valid bits are cleared.
  - Counters are set to 0.
  - mem_re_o=0, cpu_valid_o=0 and cpu_instr_o=0, all immediately.
  - A refill in progress is abandoned. The SRAM sees re drop and clears its wait counter.
- Hit:
  - hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag) & state==IDLE.
  - On a hit, cpu_valid_o=1 and cpu_instr_o = the data word selected by OFF, in the same cycle (zero latency).
  - When cpu_valid_o=0, cpu_instr_o=0.
- FSM has two states, IDLE and REFILL:
  - IDLE: when cpu_req_i is high and there is no hit and flush_i=0, latch refill tag/index from cpu_addr_i, increment miss_cnt_o, and go to REFILL.
  - REFILL: mem_re_o=1 and mem_add_o={latched tag, latched index, 2'b00}, both held stable for every cycle of the state.
  - REFILL, on mem_valid_i=1: write mem_d_i into data[latched idx], write the latched tag, set the valid bit, and return to IDLE. mem_re_o drops in the next cycle, so the SRAM's counter restarts cleanly.
  - In IDLE, mem_re_o=0 and mem_add_o=0.
- Miss latency: request in cycle 0, mem_re_o in cycles 1..1+WS, line installed at the end of cycle 1+WS, cpu_valid_o in cycle 2+WS (when the request is still present).
- hit_cnt_o increments on every cycle with cpu_valid_o=1. Both counters wrap modulo 2^32.
- Boundary conditions:
  - cpu_req_i dropped or cpu_addr_i changed during REFILL: the refill still completes and installs the latched line. Back in IDLE, the current request is looked up anew and may miss again.
  - cpu_valid_o is never asserted in REFILL, even if the address hits another line.
  - flush_i in IDLE: all valid bits are cleared at the clock edge. A same-cycle request is still served as a hit from pre-flush contents, and no refill starts in that cycle.
  - flush_i in REFILL: all valid bits are cleared and the refill continues.
  - flush_i in the same cycle as mem_valid_i: flush wins. Data and tag are written, the valid bit stays 0, and the FSM returns to IDLE.
  - Conflict miss (same index, different tag): the old line is overwritten. There is no victim handling; the cache is read-only.

Test Plan:
- Reset, WS=2, request addr 0x0000_0010 → cpu_valid_o=0 in cycles 0..3, mem_re_o=1 in cycles 1..3, mem_add_o=0x004. cpu_valid_o=1 in cycle 4 with word mem[4]; miss_cnt_o=1, hit_cnt_o=1.
- After the line install, sweep 0x10,0x14,0x18,0x1C on consecutive cycles → cpu_valid_o=1 each cycle with mem[4..7], hit_cnt_o +4, no mem_re_o activity.
- Conflict: fetch 0x010, then 0x110 (NB_LINES=16, same index 1, different tag) → second refill at mem_add_o=0x044. Refetching 0x010 misses again; miss_cnt_o=3.
- WS=0: miss → mem_re_o high for exactly 1 cycle, cpu_valid_o 2 cycles after the request.
- flush_i pulsed coincident with mem_valid_i during a refill → FSM back in IDLE, same address misses again, miss_cnt_o increments.
- rstn_i asserted mid-REFILL (cycle 2 of WS=3) → mem_re_o=0 asynchronously, counters 0. The previously cached line misses after reset release.
